// File: rtl/interrupt_ack_control_8259a_pkg.sv
// Shared constants and bit/level helpers for the 8259A interrupt acknowledge control.
// Levels are 3-bit numbers and one-hot vectors are 8 bits wide.
package interrupt_ack_control_8259a_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StWaitAck1 = 2'b01,
    StWaitAck2 = 2'b10
  } ack_state_e;

  localparam logic [2:0] SpuriousLevel = 3'd7;

  function automatic logic [2:0] bit2num(input logic [7:0] source);
    logic [2:0] num;
    num = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (source[i]) num = i[2:0];
    end
    return num;
  endfunction

  function automatic logic [7:0] num2bit(input logic [2:0] source);
    return 8'd1 << source;
  endfunction

  function automatic logic [7:0] rotate_right(input logic [7:0] source, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {source, source} >> amount;
    return doubled[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] source, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {source, source} << amount;
    return doubled[15:8];
  endfunction

  // Isolates the lowest set bit, i.e. the highest priority once rotated to bit 0.
  function automatic logic [7:0] resolv_priority(input logic [7:0] source);
    return source & (~source + 8'd1);
  endfunction

endpackage

// File: rtl/interrupt_ack_control_8259a.sv
// INTA sequencing, in-service register and priority rotation for an 8259A-style controller.
// Drives INT, latches the acknowledged level and emits the vector on the second INTA.
module interrupt_ack_control_8259a
  import interrupt_ack_control_8259a_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       inta_strobe,
  input  logic [4:0] interrupt_vector_address,
  input  logic       auto_eoi_config,
  input  logic       rotate_in_auto_eoi,
  input  logic       eoi_nonspecific,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic       set_priority,
  input  logic [2:0] command_level,
  output logic       interrupt_to_cpu,
  output logic [7:0] in_service_register,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] data_out,
  output logic       data_out_enable
);

  ack_state_e state_q;
  logic [2:0] level_q;
  logic       spurious_q;
  logic [7:0] isr_q;
  logic [2:0] rotate_q;

  logic       has_request;
  logic       first_ack;
  logic       second_ack;
  logic       aeoi_clear;
  logic [7:0] highest;
  logic [7:0] isr_clear;
  logic [7:0] isr_set;
  logic [7:0] isr_d;
  logic [2:0] rotate_d;

  assign has_request = |interrupt;
  assign first_ack   = inta_strobe && (state_q != StWaitAck2);
  assign second_ack  = inta_strobe && (state_q == StWaitAck2);
  assign aeoi_clear  = second_ack && auto_eoi_config && !spurious_q;

  assign highest = rotate_left(resolv_priority(rotate_right(isr_q, rotate_q)), rotate_q);

  // Clears come from the pre-edge ISR; the acknowledge set is applied last so it wins.
  always_comb begin
    isr_clear = 8'h00;
    if (eoi_nonspecific) isr_clear = isr_clear | highest;
    if (eoi_specific)    isr_clear = isr_clear | num2bit(command_level);
    if (aeoi_clear)      isr_clear = isr_clear | num2bit(level_q);
    isr_set = (first_ack && has_request) ? num2bit(bit2num(interrupt)) : 8'h00;
    isr_d   = (isr_q & ~isr_clear) | isr_set;
  end

  always_comb begin
    rotate_d = rotate_q;
    if (eoi_nonspecific && eoi_rotate && (isr_q != 8'h00)) begin
      rotate_d = bit2num(highest) + 3'd1;
    end else if (eoi_specific && eoi_rotate) begin
      rotate_d = command_level + 3'd1;
    end else if (set_priority) begin
      rotate_d = command_level + 3'd1;
    end else if (aeoi_clear && rotate_in_auto_eoi) begin
      rotate_d = level_q + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q                 <= StIdle;
      level_q                 <= 3'd0;
      spurious_q              <= 1'b0;
      isr_q                   <= 8'h00;
      rotate_q                <= 3'd0;
      interrupt_to_cpu        <= 1'b0;
      clear_interrupt_request <= 8'h00;
      data_out                <= 8'h00;
      data_out_enable         <= 1'b0;
    end else begin
      isr_q                   <= isr_d;
      rotate_q                <= rotate_d;
      clear_interrupt_request <= isr_set;
      data_out                <= 8'h00;
      data_out_enable         <= 1'b0;
      if (first_ack) begin
        level_q    <= has_request ? bit2num(interrupt) : SpuriousLevel;
        spurious_q <= !has_request;
      end
      case (state_q)
        StIdle: begin
          if (inta_strobe) begin
            state_q          <= StWaitAck2;
            interrupt_to_cpu <= 1'b0;
          end else if (has_request) begin
            state_q          <= StWaitAck1;
            interrupt_to_cpu <= 1'b1;
          end
        end
        StWaitAck1: begin
          if (inta_strobe) begin
            state_q          <= StWaitAck2;
            interrupt_to_cpu <= 1'b0;
          end else begin
            interrupt_to_cpu <= 1'b1;
          end
        end
        StWaitAck2: begin
          interrupt_to_cpu <= 1'b0;
          if (inta_strobe) begin
            state_q         <= StIdle;
            data_out        <= {interrupt_vector_address, level_q};
            data_out_enable <= 1'b1;
          end
        end
        default: begin
          state_q          <= StIdle;
          interrupt_to_cpu <= 1'b0;
        end
      endcase
    end
  end

  assign in_service_register      = isr_q;
  assign highest_level_in_service = highest;
  assign priority_rotate          = rotate_q;

endmodule
